// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - operand load stream and result port bundle for systolic_ctrl
//
// Purpose: groups the two handshake ports of the job sequencer.
//   ld_valid/ld_ready/ld_a/ld_b : operand load stream (beat k = column k of A, row k of B)
//   res_valid/res_ready/res_c   : captured 3x3 result, held until taken
// master = host/DMA side, slave = systolic_ctrl side.

interface systolic_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [3*DATA_W-1:0]   ld_a;
    logic [3*DATA_W-1:0]   ld_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [9*ACC_W-1:0]    res_c;

    modport master (
        output ld_valid, ld_a, ld_b, res_ready,
        input  ld_ready, res_valid, res_c
    );

    modport slave (
        input  ld_valid, ld_a, ld_b, res_ready,
        output ld_ready, res_valid, res_c
    );
endinterface

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for the 3x3 systolic_array
//
// Purpose: buffers three operand beats, clears the array, feeds the beats, waits
// for the pipeline to drain, captures C and offers it on a valid/ready port.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        systolic_ctrl_if.slave: ld_* load stream, res_* result port
//   arr_rst    reset to the array (rst OR'ed with the CLR pulse)
//   arr_a/b    lane inputs to the array, zero outside FEED
//   arr_c      accumulator outputs of the array, c1 in the low slice
//   busy       high in every state except IDLE
//   job_cnt    completed jobs, incremented on result handshake

module systolic_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ACC_W        = 64,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_ctrl_if.slave       bus,
    output logic                 arr_rst,
    output logic [3*DATA_W-1:0]  arr_a,
    output logic [3*DATA_W-1:0]  arr_b,
    input  logic [9*ACC_W-1:0]   arr_c,
    output logic                 busy,
    output logic [15:0]          job_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLR   = 3'd2,
        FEED  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state;
    logic [7:0]           cnt;
    logic [3*DATA_W-1:0]  buf_a [0:2];
    logic [3*DATA_W-1:0]  buf_b [0:2];
    logic                 arr_rst_q;
    logic                 ld_ready_q;
    logic                 res_valid_q;
    logic [9*ACC_W-1:0]   res_c_q;

    // rst reaches the array combinationally so it is cleared in the same cycle.
    assign arr_rst       = rst | arr_rst_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_c     = res_c_q;

    wire ld_fire = bus.ld_valid & ld_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
            arr_a       <= '0;
            arr_b       <= '0;
            arr_rst_q   <= 1'b0;
            ld_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_c_q     <= '0;
            busy        <= 1'b0;
            job_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ld_ready_q <= 1'b1;
                    if (ld_fire) begin
                        buf_a[0] <= bus.ld_a;
                        buf_b[0] <= bus.ld_b;
                        cnt      <= 8'd1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        buf_a[cnt[1:0]] <= bus.ld_a;
                        buf_b[cnt[1:0]] <= bus.ld_b;
                        if (cnt == 8'd2) begin
                            ld_ready_q <= 1'b0;
                            arr_rst_q  <= 1'b1;
                            cnt        <= '0;
                            state      <= CLR;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                CLR: begin
                    arr_rst_q <= 1'b0;
                    arr_a     <= buf_a[0];
                    arr_b     <= buf_b[0];
                    cnt       <= 8'd1;
                    state     <= FEED;
                end
                FEED: begin
                    // cnt is the index of the beat to present next; 3 means all fed.
                    if (cnt == 8'd3) begin
                        arr_a <= '0;
                        arr_b <= '0;
                        cnt   <= 8'd1;
                        state <= DRAIN;
                    end else begin
                        arr_a <= buf_a[cnt[1:0]];
                        arr_b <= buf_b[cnt[1:0]];
                        cnt   <= cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    // cnt counts drain cycles 1..DRAIN_CYCLES; capture on the last one.
                    if (cnt == 8'(DRAIN_CYCLES)) begin
                        res_c_q     <= arr_c;
                        res_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        job_cnt     <= job_cnt + 16'd1;
                        busy        <= 1'b0;
                        ld_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl with a behavioural 3x3 array

module tb_systolic_ctrl;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;

    logic clk = 1'b0;
    logic rst;
    logic arr_rst;
    logic [3*DATA_W-1:0] arr_a, arr_b;
    logic [9*ACC_W-1:0]  arr_c;
    logic busy;
    logic [15:0] job_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_jobs = 0;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    systolic_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DRAIN_CYCLES(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .arr_rst (arr_rst),
        .arr_a   (arr_a),
        .arr_b   (arr_b),
        .arr_c   (arr_c),
        .busy    (busy),
        .job_cnt (job_cnt)
    );

    // Behavioural systolic array: PE(i,j) sees lane i of a and lane j of b
    // delayed by i+j cycles (input skew plus neighbour hops) and accumulates.
    logic signed [31:0] ha [1:4][0:2];
    logic signed [31:0] hb [1:4][0:2];
    logic signed [63:0] acc [0:2][0:2];

    always @(posedge clk) begin
        if (arr_rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) acc[i][j] <= '0;
                for (int d = 1; d <= 4; d++) begin
                    ha[d][i] <= '0;
                    hb[d][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    logic signed [31:0] av, bv;
                    if (i + j == 0) begin
                        av = arr_a[i*32 +: 32];
                        bv = arr_b[j*32 +: 32];
                    end else begin
                        av = ha[i+j][i];
                        bv = hb[i+j][j];
                    end
                    acc[i][j] <= acc[i][j] + 64'(longint'(av) * longint'(bv));
                end
            end
            for (int i = 0; i < 3; i++) begin
                ha[1][i] <= arr_a[i*32 +: 32];
                hb[1][i] <= arr_b[i*32 +: 32];
                for (int d = 2; d <= 4; d++) begin
                    ha[d][i] <= ha[d-1][i];
                    hb[d][i] <= hb[d-1][i];
                end
            end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                arr_c[(i*3+j)*64 +: 64] = acc[i][j];
    end

    // Reference: plain matrix product, row-major packing, 64-bit wrap.
    function automatic logic [575:0] matmul(input logic [287:0] a, input logic [287:0] b);
        logic [575:0] c;
        longint s;
        c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += longint'($signed(a[(i*3+k)*32 +: 32])) * longint'($signed(b[(k*3+j)*32 +: 32]));
                c[(i*3+j)*64 +: 64] = s;
            end
        return c;
    endfunction

    function automatic logic [287:0] p32(input int v[9]);
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    function automatic logic [575:0] p64(input longint v[9]);
        logic [575:0] r;
        for (int i = 0; i < 9; i++) r[i*64 +: 64] = v[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_beats(input logic [287:0] a, input logic [287:0] b, input int gap, input string nm);
        int n;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.ld_valid = 1'b0;
                    chk({nm, " gap ready/busy"}, {bus.ld_ready, busy}, 2'b11);
                end
            end
            @(negedge clk);
            bus.ld_valid = 1'b1;
            bus.ld_a = {a[(6+k)*32 +: 32], a[(3+k)*32 +: 32], a[k*32 +: 32]};
            bus.ld_b = {b[(k*3+2)*32 +: 32], b[(k*3+1)*32 +: 32], b[(k*3)*32 +: 32]};
            n = 0;
            while (!bus.ld_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk({nm, " ld_ready timeout"}, 0, 1);
            @(posedge clk);
            #1;
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic run_job(input logic [287:0] a, input logic [287:0] b, input logic [575:0] exp,
                           input int gap, input int hold, input string nm);
        int n;
        logic rdy_seen;
        load_beats(a, b, gap, nm);
        rdy_seen = 1'b0;
        n = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.ld_ready) rdy_seen = 1'b1;
            if (bus.res_valid) begin
                n = e;
                break;
            end
        end
        chk({nm, " latency"}, n, 9);
        chk({nm, " ld_ready low while busy"}, rdy_seen, 0);
        chk({nm, " res_c"}, bus.res_c, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.ld_valid = 1'b1;
            bus.ld_a = 96'($urandom);
            chk({nm, " hold valid/ready/busy"}, {bus.res_valid, bus.ld_ready, busy}, 3'b101);
            chk({nm, " hold res_c"}, bus.res_c, exp);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        exp_jobs = (exp_jobs + 1) & 16'hFFFF;
        chk({nm, " after take valid/busy"}, {bus.res_valid, busy}, 2'b00);
        chk({nm, " job_cnt"}, job_cnt, exp_jobs);
    endtask

    typedef struct {
        string        nm;
        logic [287:0] a;
        logic [287:0] b;
        logic [575:0] exp;
        int           gap;
        int           hold;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [287:0] ma, mb, ident, b19, m123, zero;
        ident = p32('{1, 0, 0, 0, 1, 0, 0, 0, 1});
        b19   = p32('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        m123  = b19;
        zero  = '0;
        vecs[0] = '{"T1", ident, b19, p64('{1, 2, 3, 4, 5, 6, 7, 8, 9}), 0, 0};
        vecs[1] = '{"T2", m123, m123, p64('{30, 36, 42, 66, 81, 96, 102, 126, 150}), 0, 0};
        vecs[2] = '{"T5", zero, m123, '0, 0, 0};
        vecs[3] = '{"T3", {9{32'h8000_0000}}, {9{32'hFFFF_FFFF}}, {9{64'h1_8000_0000}}, 0, 2};
        vecs[4] = '{"T4", m123, m123, p64('{30, 36, 42, 66, 81, 96, 102, 126, 150}), 4, 20};

        rst = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_a = '0;
        bus.ld_b = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset arr_rst/ld_ready/busy/res_valid", {arr_rst, bus.ld_ready, busy, bus.res_valid}, 4'b1000);
        chk("reset arr_a/arr_b", {arr_a, arr_b}, '0);
        chk("reset res_c", bus.res_c, '0);
        chk("reset job_cnt", job_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle arr_rst", arr_rst, 0);

        for (int v = 0; v < 5; v++)
            run_job(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].gap, vecs[v].hold, vecs[v].nm);

        // T6: abort during FEED, then a clean T1 job.
        load_beats(m123, m123, 0, "T6");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("T6 feeding busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("T6 rst arr_rst/ld_ready/busy/res_valid", {arr_rst, bus.ld_ready, busy, bus.res_valid}, 4'b1000);
        chk("T6 rst arr_a/arr_b", {arr_a, arr_b}, '0);
        chk("T6 rst job_cnt", job_cnt, 0);
        exp_jobs = 0;
        @(negedge clk);
        rst = 1'b0;
        run_job(vecs[0].a, vecs[0].b, vecs[0].exp, 0, 1, "T6 T1");

        // Random jobs against the matrix-product model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 9; i++) begin
                ma[i*32 +: 32] = $urandom;
                mb[i*32 +: 32] = $urandom;
            end
            run_job(ma, mb, matmul(ma, mb), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "RND");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
